// File: rtl/wb_write_arbiter_if.sv
// Bundle for the two-requester register-file write arbiter: both writeback
// request channels plus the registered register-file write port and status.
// The slave modport is the arbiter; the master modport is the requester side.
interface wb_write_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             REQ0_VALID;
    logic [AW-1:0]    REQ0_ADDR;
    logic [WIDTH-1:0] REQ0_DATA;
    logic             REQ0_READY;

    logic             REQ1_VALID;
    logic [AW-1:0]    REQ1_ADDR;
    logic [WIDTH-1:0] REQ1_DATA;
    logic             REQ1_READY;

    logic             WE3;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD3;
    logic             ZERO_DROP;
    logic [15:0]      STALL_CNT;

    modport slave (
        input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        output REQ0_READY, REQ1_READY,
        output WE3, A3, WD3, ZERO_DROP, STALL_CNT
    );

    modport master (
        output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        input  REQ0_READY, REQ1_READY,
        input  WE3, A3, WD3, ZERO_DROP, STALL_CNT
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write arbiter: merges ALU writeback (requester 0) and load
// writeback (requester 1) into one registered write port. Grants are
// combinational from the VALIDs; by default ties are broken round-robin.
// Build option: define WB_ARB_FIXED_PRIO_EN to make requester 1 always win
// a tie (the round-robin pointer is then not built).
// Writes to register 0 are swallowed and flagged on ZERO_DROP.
module wb_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    wb_write_arbiter_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       valid_vec;
    logic [1:0]       grant_vec;
    logic [1:0]       stall_vec;
    logic             xfer;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             sel_zero;

    logic             we_reg;
    logic [AW-1:0]    a3_reg;
    logic [WIDTH-1:0] wd3_reg;
    logic             zero_drop_reg;
    logic [15:0]      stall_cnt_reg;

    assign valid_vec = {bus.REQ1_VALID, bus.REQ0_VALID};

`ifdef WB_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 wins every tie; nothing granted in reset
    always_comb begin
        grant_vec = 2'b00;
        if (!RST) begin
            grant_vec[1] = valid_vec[1];
            grant_vec[0] = valid_vec[0] & ~valid_vec[1];
        end
    end
`else
    logic prio_reg;
    logic prio_next;

    // Round-robin grant: a lone requester wins outright, a tie goes to prio
    always_comb begin
        grant_vec = 2'b00;
        prio_next = prio_reg;
        if (!RST) begin
            if (valid_vec == 2'b11) begin
                grant_vec[0] = ~prio_reg;
                grant_vec[1] = prio_reg;
            end else begin
                grant_vec = valid_vec;
            end
            // Point at whichever requester did not get this grant
            if (grant_vec[0]) begin
                prio_next = 1'b1;
            end else if (grant_vec[1]) begin
                prio_next = 1'b0;
            end
        end
    end

    // Priority pointer register; requester 0 favoured out of reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end
`endif

    // A requester stalls when it asks and is not granted
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stall
            assign stall_vec[gi] = valid_vec[gi] & ~grant_vec[gi];
        end
    endgenerate

    assign xfer     = |grant_vec;
    assign sel_addr = grant_vec[1] ? bus.REQ1_ADDR : bus.REQ0_ADDR;
    assign sel_data = grant_vec[1] ? bus.REQ1_DATA : bus.REQ0_DATA;
    assign sel_zero = (sel_addr == '0);

    // Registered write port, zero-register filter and saturating stall count
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_reg        <= 1'b0;
            a3_reg        <= '0;
            wd3_reg       <= '0;
            zero_drop_reg <= 1'b0;
            stall_cnt_reg <= 16'h0000;
        end else begin
            we_reg        <= xfer & ~sel_zero;
            zero_drop_reg <= xfer & sel_zero;
            if (xfer && !sel_zero) begin
                a3_reg  <= sel_addr;
                wd3_reg <= sel_data;
            end
            if ((|stall_vec) && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'h0001;
            end
        end
    end

    // Outputs are forced to zero while reset is high so a write accepted on
    // the cycle just before reset never reaches the register file.
    assign bus.REQ0_READY = grant_vec[0];
    assign bus.REQ1_READY = grant_vec[1];
    assign bus.WE3        = we_reg & ~RST;
    assign bus.A3         = RST ? '0 : a3_reg;
    assign bus.WD3        = RST ? '0 : wd3_reg;
    assign bus.ZERO_DROP  = zero_drop_reg & ~RST;
    assign bus.STALL_CNT  = RST ? 16'h0000 : stall_cnt_reg;
endmodule
